// File: rtl/dma_write_cmd_seq_pkg.sv
// rtl/dma_write_cmd_seq_pkg.sv - shared state encoding and command layout for the write command sequencer
package dma_write_cmd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    localparam int CMD_W    = 64;
    localparam int ADDR_LSB = 32;
    localparam int LEN_LSB  = 0;

endpackage

// File: rtl/dma_write_cmd_seq_intr_edge_det.sv
// rtl/dma_write_cmd_seq_intr_edge_det.sv - registered rising-edge detector for the DMA completion interrupt
module dma_write_cmd_seq_intr_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/dma_write_cmd_seq.sv
// rtl/dma_write_cmd_seq.sv - emits one DMA write command per tensor row, paced by completion interrupts
module dma_write_cmd_seq
    import dma_write_cmd_seq_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 32,
    parameter int CNT_W      = 16,
    parameter int ALIGN_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  row_bytes,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [CNT_W-1:0]  row_count,
    input  logic              introut,
    output logic [CMD_W-1:0]  W_DMA_CMD,
    output logic              W_DMA_Valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  rows_issued
);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, stride_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CMD_W-1:0]  cmd_q, cmd_issue;
    logic              intr_rise, intr_pend, desc_bad, advance;

    dma_write_cmd_seq_intr_edge_det u_intr_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (introut),
        .rise (intr_rise)
    );

    assign desc_bad = (cnt_q == '0) || (len_q == '0) || (len_q[ALIGN_LOG2-1:0] != '0);
    // a completion that lands during ISSUE is parked in intr_pend and consumed in WAIT
    assign advance  = intr_rise | intr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        W_DMA_Valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cmd_issue   = '0;
        cmd_issue[ADDR_LSB +: ADDR_W] = cur_addr;
        cmd_issue[LEN_LSB  +: LEN_W]  = len_q;
        W_DMA_CMD   = cmd_q;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                state_nxt = desc_bad ? ST_FINISH : ST_ISSUE;
            end
            ST_ISSUE: begin
                busy        = 1'b1;
                W_DMA_Valid = 1'b1;
                W_DMA_CMD   = cmd_issue;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (advance) state_nxt = (rows_issued == cnt_q) ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr    <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            intr_pend   <= 1'b0;
            err         <= 1'b0;
            rows_issued <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr    <= base_addr;
                        stride_q    <= row_stride;
                        len_q       <= row_bytes;
                        cnt_q       <= row_count;
                        intr_pend   <= 1'b0;
                        err         <= 1'b0;
                        rows_issued <= '0;
                    end
                end
                ST_CHECK: begin
                    if (desc_bad) err <= 1'b1;
                end
                ST_ISSUE: begin
                    cmd_q       <= cmd_issue;
                    cur_addr    <= cur_addr + stride_q;
                    rows_issued <= rows_issued + CNT_W'(1);
                    intr_pend   <= intr_rise;
                end
                ST_WAIT: begin
                    if (advance) intr_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_cmd_seq.sv
// tb/tb_dma_write_cmd_seq.sv - scoreboard bench for the write command sequencer
module tb_dma_write_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] row_bytes;
    logic [31:0] row_stride;
    logic [15:0] row_count;
    logic        introut;
    logic [63:0] W_DMA_CMD;
    logic        W_DMA_Valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rows_issued;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    dma_write_cmd_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .row_bytes   (row_bytes),
        .row_stride  (row_stride),
        .row_count   (row_count),
        .introut     (introut),
        .W_DMA_CMD   (W_DMA_CMD),
        .W_DMA_Valid (W_DMA_Valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rows_issued (rows_issued)
    );

    function automatic void push_desc(input logic [31:0] base, input logic [31:0] bytes,
                                      input logic [31:0] stride, input logic [15:0] rows);
        logic [31:0] a;
        a = base;
        if (rows == 16'd0 || bytes == 32'd0 || bytes[3:0] != 4'd0) return;
        for (int r = 0; r < int'(rows); r++) begin
            exp_q.push_back({a, bytes});
            a = a + stride;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [31:0] base, input logic [31:0] bytes,
                               input logic [31:0] stride, input logic [15:0] rows);
        base_addr  = base;
        row_bytes  = bytes;
        row_stride = stride;
        row_count  = rows;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic sb_expect_cmd(input string name, input int limit, output int n);
        logic [63:0] e;
        bit seen;
        seen = 0;
        n    = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (W_DMA_Valid === 1'b1) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: no W_DMA_Valid within %0d cycles", name, limit);
        end else if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s_unexpected: cmd %h strobed, required no strobe", name, W_DMA_CMD);
        end else begin
            e = exp_q.pop_front();
            if (W_DMA_CMD !== e) begin
                fails++;
                $display("FAIL %s_cmd: got %h, required %h", name, W_DMA_CMD, e);
            end
        end
    endtask

    task automatic run_seq(input string name, input logic [31:0] base, input logic [31:0] bytes,
                           input logic [31:0] stride, input logic [15:0] rows);
        int n;
        push_desc(base, bytes, stride, rows);
        drive_start(base, bytes, stride, rows);
        for (int r = 0; r < int'(rows); r++) begin
            sb_expect_cmd(name, 8, n);
            tests++;
            if (n !== ((r == 0) ? 2 : 1)) begin
                fails++;
                $display("FAIL %s_latency row %0d: got %0d cycles, required %0d", name, r, n, (r == 0) ? 2 : 1);
            end
            tick();
            introut = 1'b1;
            tick();
            introut = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || rows_issued !== rows) begin
            fails++;
            $display("FAIL %s_finish: done=%b busy=%b rows=%0d, required done=1 busy=0 rows=%0d",
                     name, done, busy, rows_issued, rows);
        end
        tick();
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || rows_issued !== rows || err !== 1'b0 || W_DMA_Valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: done=%b rows=%0d err=%b valid=%b, required 0/%0d/0/0",
                     name, done, rows_issued, err, W_DMA_Valid, rows);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; introut = 1'b0;
        base_addr = '0; row_bytes = '0; row_stride = '0; row_count = '0;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if (W_DMA_CMD !== 64'd0 || W_DMA_Valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_cmd: cmd=%h valid=%b, required 0/0", W_DMA_CMD, W_DMA_Valid);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rows_issued !== 16'd0) begin
            fails++;
            $display("FAIL reset_status: busy=%b done=%b err=%b rows=%0d, required all 0", busy, done, err, rows_issued);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_seq("basic", 32'h1000_0000, 32'h100, 32'h400, 16'd3);
    endtask

    task automatic test_misaligned();
        drive_start(32'h1000, 32'h104, 32'h100, 16'd2);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || W_DMA_Valid !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_check: busy=%b valid=%b done=%b, required 1/0/0", busy, W_DMA_Valid, done);
        end
        tick();
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== 1'b1 || W_DMA_Valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_finish: done=%b err=%b valid=%b busy=%b, required 1/1/0/0",
                     done, err, W_DMA_Valid, busy);
        end
        tick();
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL misaligned_hold: done=%b busy=%b err=%b, required 0/0/1", done, busy, err);
        end
    endtask

    task automatic test_zero_rows();
        drive_start(32'h2000, 32'h40, 32'h40, 16'd0);
        tick();
        @(negedge clk);
        tests++;
        if (err !== 1'b1 || done !== 1'b1 || W_DMA_Valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_rows: err=%b done=%b valid=%b, required 1/1/0", err, done, W_DMA_Valid);
        end
        tick();
        run_seq("zero_recover", 32'h2000, 32'h40, 32'h40, 16'd2);
    endtask

    task automatic test_busy_ignore();
        int n;
        push_desc(32'h3000, 32'h20, 32'h100, 16'd2);
        drive_start(32'h3000, 32'h20, 32'h100, 16'd2);
        sb_expect_cmd("busy_ignore", 8, n);
        tick();
        base_addr = 32'hDEAD_0000;
        row_count = 16'd5;
        start     = 1'b1;
        introut   = 1'b1;
        tick();
        start     = 1'b0;
        sb_expect_cmd("busy_ignore", 8, n);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            tests++;
            if (W_DMA_Valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || rows_issued !== 16'd2) begin
                fails++;
                $display("FAIL held_level cycle %0d: valid=%b busy=%b done=%b rows=%0d, required 0/1/0/2",
                         i, W_DMA_Valid, busy, done, rows_issued);
            end
        end
        introut = 1'b0;
        tick();
        introut = 1'b1;
        tick();
        introut = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || rows_issued !== 16'd2) begin
            fails++;
            $display("FAIL busy_ignore_finish: done=%b rows=%0d, required 1/2", done, rows_issued);
        end
        tick();
    endtask

    task automatic test_wrap();
        int n;
        push_desc(32'hFFFF_FF00, 32'h80, 32'h200, 16'd2);
        drive_start(32'hFFFF_FF00, 32'h80, 32'h200, 16'd2);
        sb_expect_cmd("wrap", 8, n);
        introut = 1'b1;
        tick();
        introut = 1'b0;
        sb_expect_cmd("wrap_issue_intr", 8, n);
        tests++;
        if (n !== 2) begin
            fails++;
            $display("FAIL issue_cycle_intr: got %0d cycles to next cmd, required 2", n);
        end
        tick();
        introut = 1'b1;
        tick();
        introut = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || rows_issued !== 16'd2) begin
            fails++;
            $display("FAIL wrap_finish: done=%b err=%b rows=%0d, required 1/0/2", done, err, rows_issued);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        push_desc(32'h4000, 32'h40, 32'h40, 16'd4);
        drive_start(32'h4000, 32'h40, 32'h40, 16'd4);
        sb_expect_cmd("reset_mid", 8, n);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (W_DMA_Valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || W_DMA_CMD !== 64'd0 || rows_issued !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: valid=%b busy=%b done=%b cmd=%h rows=%0d, required all 0",
                     W_DMA_Valid, busy, done, W_DMA_CMD, rows_issued);
        end
        exp_q.delete();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || W_DMA_Valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: done=%b busy=%b valid=%b, required 0/0/0", done, busy, W_DMA_Valid);
        end
        run_seq("after_reset", 32'h5000, 32'h30, 32'h80, 16'd2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_zero_rows();
        test_busy_ignore();
        test_wrap();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d commands outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
